// File: rtl/decimal_entry_controller.sv
// ---------------------------------------------------------------------------
// decimal_entry_controller
//
// Purpose:
//   Three-button entry of a decimal number 0..999 one digit at a time
//   (hundreds, tens, ones). The completed entry is published as an 8-bit
//   binary value. Entries above 255 saturate to 255 and raise overflow.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   btn_inc      in   1  level button, each press advances the edited digit
//   btn_next     in   1  level button, each press confirms the edited digit
//   btn_clear    in   1  level button, each press abandons the entry
//   cur_digit    out  4  BCD digit being edited (0..9)
//   digit_idx    out  2  0 hundreds, 1 tens, 2 ones, 3 done
//   value        out  8  last completed entry, binary
//   value_valid  out  1  one-cycle pulse when value updates
//   overflow     out  1  last completed entry exceeded 255
//
// Build option:
//   INPUT_SYNC_EN  when defined, each button passes through a two-flop
//                  synchronizer before press detection (+2 cycles latency).
// ---------------------------------------------------------------------------
module decimal_entry_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_clear,
  output logic [3:0] cur_digit,
  output logic [1:0] digit_idx,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ST_H    = 2'd0,
    ST_T    = 2'd1,
    ST_O    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] hundreds, tens;
  logic [3:0] hundreds_nxt, tens_nxt, cur_digit_nxt;
  logic [7:0] value_nxt;
  logic       valid_nxt, overflow_nxt;

  logic       inc_s, next_s, clear_s;
  logic       inc_prev, next_prev, clear_prev;
  logic       inc_press, next_press, clear_press;
  logic [9:0] sum;

`ifdef INPUT_SYNC_EN
  // Two-flop synchronizer per button, ordered {clear, next, inc}.
  logic [2:0] sync_1, sync_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {btn_clear, btn_next, btn_inc};
      sync_2 <= sync_1;
    end
  end

  assign {clear_s, next_s, inc_s} = sync_2;
`else
  assign {clear_s, next_s, inc_s} = {btn_clear, btn_next, btn_inc};
`endif

  // Rising-edge detection: a held button yields one press only.
  assign inc_press   = inc_s   & ~inc_prev;
  assign next_press  = next_s  & ~next_prev;
  assign clear_press = clear_s & ~clear_prev;

  // 10 bits hold the largest entry 999 without wrapping.
  assign sum = ({6'd0, hundreds} * 10'd100) + ({6'd0, tens} * 10'd10)
             + {6'd0, cur_digit};

  assign digit_idx = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_H;
      cur_digit   <= '0;
      hundreds    <= '0;
      tens        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
      inc_prev    <= 1'b0;
      next_prev   <= 1'b0;
      clear_prev  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_digit   <= cur_digit_nxt;
      hundreds    <= hundreds_nxt;
      tens        <= tens_nxt;
      value       <= value_nxt;
      value_valid <= valid_nxt;
      overflow    <= overflow_nxt;
      inc_prev    <= inc_s;
      next_prev   <= next_s;
      clear_prev  <= clear_s;
    end
  end

  // Priority clear > next > inc; lower-priority presses in the same cycle
  // are simply dropped.
  always_comb begin
    state_nxt     = state;
    cur_digit_nxt = cur_digit;
    hundreds_nxt  = hundreds;
    tens_nxt      = tens;
    value_nxt     = value;
    valid_nxt     = 1'b0;
    overflow_nxt  = overflow;

    if (clear_press) begin
      state_nxt     = ST_H;
      cur_digit_nxt = '0;
      hundreds_nxt  = '0;
      tens_nxt      = '0;
      overflow_nxt  = 1'b0;
    end else if (next_press) begin
      case (state)
        ST_H: begin
          hundreds_nxt  = cur_digit;
          cur_digit_nxt = '0;
          state_nxt     = ST_T;
        end
        ST_T: begin
          tens_nxt      = cur_digit;
          cur_digit_nxt = '0;
          state_nxt     = ST_O;
        end
        ST_O: begin
          state_nxt = ST_DONE;
          valid_nxt = 1'b1;
          if (sum <= 10'd255) begin
            value_nxt    = sum[7:0];
            overflow_nxt = 1'b0;
          end else begin
            value_nxt    = 8'd255;
            overflow_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt     = ST_H;
          cur_digit_nxt = '0;
          hundreds_nxt  = '0;
          tens_nxt      = '0;
          overflow_nxt  = 1'b0;
        end
      endcase
    end else if (inc_press && state != ST_DONE) begin
      cur_digit_nxt = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
    end
  end

endmodule

// File: tb/tb_decimal_entry_controller.sv
// ---------------------------------------------------------------------------
// tb_decimal_entry_controller
//
// Drives directed button sequences into decimal_entry_controller. Completed
// entries are pushed to a scoreboard queue; a monitor pops and compares each
// time value_valid is seen. Works in both INPUT_SYNC_EN builds.
// ---------------------------------------------------------------------------
module tb_decimal_entry_controller;

`ifdef INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_inc, btn_next, btn_clear;
  logic [3:0] cur_digit;
  logic [1:0] digit_idx;
  logic [7:0] value;
  logic       value_valid;
  logic       overflow;

  int checkCount = 0;
  int failCount  = 0;
  int validCount = 0;

  // Expected {overflow, value} per completed entry
  logic [8:0] expQ[$];

  decimal_entry_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_inc    (btn_inc),
    .btn_next   (btn_next),
    .btn_clear  (btn_clear),
    .cur_digit  (cur_digit),
    .digit_idx  (digit_idx),
    .value      (value),
    .value_valid(value_valid),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every value_valid pulse must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (rst_n && value_valid) begin
      validCount++;
      if (expQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL unexpected_valid: actual=%0d required=none", value);
      end else begin
        logic [8:0] e;
        e = expQ.pop_front();
        checkOutput("sb_value", value, e[7:0]);
        checkOutput("sb_overflow", overflow, e[8]);
      end
    end
  end

  // Drive buttons for 'hold' cycles, release, then let the pipeline settle.
  task automatic applyStimulus(input logic inc, input logic nxt, input logic clr,
                               input int hold);
    @(negedge clk);
    btn_inc = inc; btn_next = nxt; btn_clear = clr;
    repeat (hold) @(negedge clk);
    btn_inc = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic enterDigit(input int d);
    repeat (d) applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
  endtask

  // Ones-digit confirm with press-to-valid latency measurement.
  task automatic finishEntry(input int ones, input logic [7:0] expVal,
                             input logic expOvf);
    int cycles;
    bit seen;
    repeat (ones) applyStimulus(1'b1, 1'b0, 1'b0, 1);
    expQ.push_back({expOvf, expVal});
    @(negedge clk);
    btn_next = 1'b1;
    cycles = 0;
    seen = 0;
    while (!seen && cycles < 10) begin
      @(negedge clk);
      cycles++;
      if (value_valid) seen = 1;
      if (cycles == 1) btn_next = 1'b0;
    end
    btn_next = 1'b0;
    checkOutput("valid_latency", seen ? cycles : 99, 1 + LAT);
    repeat (LAT + 2) @(negedge clk);
  endtask

  initial begin
    int vc;
    rst_n = 1'b0;
    btn_inc = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    #23;
    checkOutput("rst_cur_digit", cur_digit, 0);
    checkOutput("rst_digit_idx", digit_idx, 0);
    checkOutput("rst_value", value, 0);
    checkOutput("rst_value_valid", value_valid, 0);
    checkOutput("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Entry 1,2,3
    vc = validCount;
    enterDigit(1);
    enterDigit(2);
    finishEntry(3, 8'd123, 1'b0);
    checkOutput("e123_value", value, 123);
    checkOutput("e123_overflow", overflow, 0);
    checkOutput("e123_digit_idx", digit_idx, 3);
    checkOutput("e123_valid_pulses", validCount - vc, 1);

    // Entry 2,5,6 saturates, then next starts over
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    enterDigit(2);
    enterDigit(5);
    finishEntry(6, 8'd255, 1'b1);
    checkOutput("e256_value", value, 255);
    checkOutput("e256_overflow", overflow, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("restart_digit_idx", digit_idx, 0);
    checkOutput("restart_overflow", overflow, 0);
    checkOutput("restart_value", value, 255);
    checkOutput("restart_cur_digit", cur_digit, 0);

    // Ten incs wrap 9 -> 0, then a long hold counts once
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput($sformatf("inc_seq_%0d", i), cur_digit, i % 10);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 20);
    checkOutput("inc_held", cur_digit, 1);

    // inc+next together with cur_digit=4: next wins, hundreds=4
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("pre_pri_cur_digit", cur_digit, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("pri_digit_idx", digit_idx, 1);
    checkOutput("pri_cur_digit", cur_digit, 0);
    enterDigit(0);
    finishEntry(0, 8'd255, 1'b1);   // 400 saturates, proving hundreds=4
    applyStimulus(1'b0, 1'b1, 1'b0, 1);

    // clear+next together in T: clear wins
    enterDigit(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("clrnext_digit_idx", digit_idx, 0);
    checkOutput("clrnext_cur_digit", cur_digit, 0);

    // Complete 1,2,3 then abandon a partial entry
    enterDigit(1);
    enterDigit(2);
    finishEntry(3, 8'd123, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    vc = validCount;
    enterDigit(7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("clr_digit_idx", digit_idx, 0);
    checkOutput("clr_cur_digit", cur_digit, 0);
    checkOutput("clr_value", value, 123);
    checkOutput("clr_no_valid", validCount - vc, 0);
    enterDigit(0);
    enterDigit(4);
    finishEntry(2, 8'd42, 1'b0);
    checkOutput("e042_value", value, 42);
    checkOutput("e042_overflow", overflow, 0);

    // Reset in O discards the partial entry
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    enterDigit(1);
    enterDigit(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("preRst_digit_idx", digit_idx, 2);
    vc = validCount;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_value", value, 0);
    checkOutput("midrst_digit_idx", digit_idx, 0);
    checkOutput("midrst_cur_digit", cur_digit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    checkOutput("postrst_value", value, 0);
    checkOutput("postrst_overflow", overflow, 0);
    checkOutput("postrst_digit_idx", digit_idx, 0);
    checkOutput("postrst_cur_digit", cur_digit, 0);
    checkOutput("postrst_no_valid", validCount - vc, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
